// File: rtl/sound_player.sv
`default_nettype none
// ============================================================================
// Module   : sound_player
// Purpose  : Streams signed samples from an external memory and renders them
//            as an attenuated, offset-binary PWM audio signal.
// Revision : 1.0 - initial release
// ============================================================================
module sound_player #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int PWM_W          = 8,
  parameter int CLK_PER_SAMPLE = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [1:0]        att,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pwm,
  output logic [DATA_W-1:0] data_rd,
  output logic              busy,
  output logic              done
);

  localparam int               TMR_W      = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 2;
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(CLK_PER_SAMPLE - 1);
  localparam logic [PWM_W-1:0] c_DUTY_MSB = PWM_W'(1) << (PWM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_loop;
  logic [1:0]          r_att;
  logic [ADDR_W-1:0]   r_start_addr;
  logic [ADDR_W-1:0]   r_length;
  logic [ADDR_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [TMR_W-1:0]    r_timer;
  logic [PWM_W-1:0]    r_pwm_cnt;
  logic [PWM_W-1:0]    r_duty;
  logic                r_rd_en;
  logic                r_pwm;
  logic                r_done;
  logic [DATA_W-1:0]   r_data_rd;

  logic signed [PWM_W-1:0] w_top_shifted;
  logic [PWM_W-1:0]        w_duty_new;
  logic [PWM_W-1:0]        w_duty_nxt;
  logic                    w_pwm_en;

  // Top bits of an arithmetic shift equal the arithmetic shift of the top bits.
  assign w_top_shifted = $signed(rd_data[DATA_W-1 -: PWM_W]) >>> r_att;
  assign w_duty_new    = w_top_shifted ^ c_DUTY_MSB;

  // PWM is registered, so gate it with the state and duty of the next cycle.
  assign w_pwm_en   = !stop && ((r_state == S_FETCH) || (r_state == S_LOAD) ||
                                ((r_state == S_PLAY) && (r_timer != c_TMR_LAST)));
  assign w_duty_nxt = (r_state == S_LOAD) ? w_duty_new : r_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_loop       <= 1'b0;
      r_att        <= 2'd0;
      r_start_addr <= '0;
      r_length     <= '0;
      r_remaining  <= '0;
      r_rd_addr    <= '0;
      r_timer      <= '0;
      r_pwm_cnt    <= '0;
      r_duty       <= '0;
      r_rd_en      <= 1'b0;
      r_pwm        <= 1'b0;
      r_done       <= 1'b0;
      r_data_rd    <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      r_pwm   <= w_pwm_en && (r_pwm_cnt < w_duty_nxt);
      if (r_state != S_IDLE) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
        r_timer   <= r_timer + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_loop       <= loop;
            r_att        <= att;
            r_start_addr <= start_addr;
            r_length     <= length;
            r_remaining  <= length;
            r_pwm_cnt    <= '0;
            r_duty       <= '0;
            if (length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_FETCH;
              r_rd_en   <= 1'b1;
              r_rd_addr <= start_addr;
              r_timer   <= '0;
            end
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_data_rd <= rd_data;
          r_duty    <= w_duty_new;
          r_state   <= S_PLAY;
        end
        S_PLAY: begin
          if (r_timer == c_TMR_LAST) begin
            if (r_remaining > ADDR_W'(1)) begin
              r_remaining <= r_remaining - 1'b1;
              r_rd_addr   <= r_rd_addr + 1'b1;
              r_rd_en     <= 1'b1;
              r_timer     <= '0;
              r_state     <= S_FETCH;
            end else if (r_loop) begin
              r_remaining <= r_length;
              r_rd_addr   <= r_start_addr;
              r_rd_en     <= 1'b1;
              r_timer     <= '0;
              r_state     <= S_FETCH;
            end else begin
              r_data_rd <= '0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_data_rd <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort wins over everything, including a same-cycle fetch or done.
      if (stop && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_rd_en   <= 1'b0;
        r_done    <= 1'b0;
        r_data_rd <= '0;
      end
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign pwm     = r_pwm;
  assign data_rd = r_data_rd;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sound_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_player
// Purpose  : Self-checking bench for sound_player against a cycle-indexed model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_player;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int PWM_W      = 4;
  localparam int CPS        = 16;
  localparam int PWM_PERIOD = 1 << PWM_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [1:0]        att = 2'd0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              pwm;
  logic [DATA_W-1:0] data_rd;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [256];
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              rd_en;
    logic              pwm;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] data_rd;
  } obs_t;

  sound_player #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PWM_W(PWM_W), .CLK_PER_SAMPLE(CPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .att(att),
    .start_addr(start_addr), .length(length), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pwm(pwm), .data_rd(data_rd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data valid one cycle after rd_en, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

  function automatic obs_t observe();
    return '{busy, done, rd_en, pwm, rd_addr, data_rd};
  endfunction

  // Offset-binary duty from plain integer arithmetic.
  function automatic int duty_of(logic [DATA_W-1:0] s, int a);
    int v;
    v = int'($signed(s));
    v = v >>> a;
    return (v + 32768) >> (DATA_W - PWM_W);
  endfunction

  // Expected outputs at cycle c after the start edge (c>=1), clip length >= 1.
  // Each sample slot is CPS cycles: fetch, load, then play.
  function automatic obs_t model(int c, int sa, int len, bit lp, int a);
    obs_t e;
    int   idx, ph, total, d_cur;
    e       = '0;
    total   = len * CPS;
    e.rd_addr = 8'(sa + len - 1);
    if (lp || c <= total) begin
      idx       = (c - 1) / CPS;
      ph        = (c - 1) % CPS;
      e.busy    = 1'b1;
      e.rd_en   = (ph == 0);
      e.rd_addr = 8'(sa + idx % len);
      d_cur     = 0;
      if (ph >= 2) begin
        e.data_rd = mem[8'(sa + idx % len)];
        d_cur     = duty_of(e.data_rd, a);
      end else if (idx > 0) begin
        e.data_rd = mem[8'(sa + (idx - 1) % len)];
        d_cur     = duty_of(e.data_rd, a);
      end
      e.pwm = (ph != 0) && (((c - 2) % PWM_PERIOD) < d_cur);
    end else if (c == total + 1) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic launch(input logic [7:0] sa, input logic [7:0] ln, input logic lp,
                        input logic [1:0] a);
    @(negedge clk);
    start_addr = sa; length = ln; loop = lp; att = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t g;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    g = observe();
    checks++;
    if (g !== obs_t'('0)) begin
      errors++; $display("FAIL reset_state: got %h want %h", g, obs_t'('0));
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    obs_t g, e;
    int win[3];
    int exp_win[3];
    int done_cyc;
    win = '{0, 0, 0}; exp_win = '{8, 15, 0}; done_cyc = -1;
    mem[8'h10] = 16'h0000; mem[8'h11] = 16'h7FFF; mem[8'h12] = 16'h8000;
    launch(8'h10, 8'd3, 1'b0, 2'd0);
    for (int c = 1; c <= 52; c++) begin
      if (c > 1) @(negedge clk);
      g = observe(); e = model(c, 'h10, 3, 1'b0, 0);
      checks++;
      if (g !== e) begin errors++; $display("FAIL basic c=%0d: got %h want %h", c, g, e); end
      if (c >= 3 && c <= 50 && pwm === 1'b1) win[(c - 3) / 16]++;
      if (done === 1'b1) done_cyc = c;
    end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (win[w] != exp_win[w]) begin
        errors++; $display("FAIL basic_pwm_window%0d: got %0d want %0d", w, win[w], exp_win[w]);
      end
    end
    checks++;
    if (done_cyc != 49) begin errors++; $display("FAIL basic_done_cycle: got %0d want 49", done_cyc); end
  endtask

  task automatic test_atten();
    obs_t g, e;
    logic [15:0] smp[2];
    int a_set[2];
    int exp_hi[2];
    int hi;
    smp = '{16'h8000, 16'h7FFF}; a_set = '{1, 3}; exp_hi = '{4, 8};
    for (int k = 0; k < 2; k++) begin
      mem[8'h20] = smp[k]; mem[8'h21] = smp[k]; hi = 0;
      launch(8'h20, 8'd2, 1'b0, 2'(a_set[k]));
      for (int c = 1; c <= 35; c++) begin
        if (c > 1) @(negedge clk);
        g = observe(); e = model(c, 'h20, 2, 1'b0, a_set[k]);
        checks++;
        if (g !== e) begin errors++; $display("FAIL atten%0d c=%0d: got %h want %h", k, c, g, e); end
        if (c >= 3 && c <= 18 && pwm === 1'b1) hi++;
      end
      checks++;
      if (hi != exp_hi[k]) begin errors++; $display("FAIL atten%0d_pwm_high: got %0d want %0d", k, hi, exp_hi[k]); end
    end
  endtask

  task automatic test_loop_stop();
    obs_t g, e;
    logic [1:0] a;
    a = 2'($urandom_range(0, 3));
    mem[8'hFF] = 16'($urandom); mem[8'h00] = 16'($urandom);
    launch(8'hFF, 8'd2, 1'b1, a);
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge clk);
      g = observe(); e = model(c, 'hFF, 2, 1'b1, int'(a));
      checks++;
      if (g !== e) begin errors++; $display("FAIL loop c=%0d: got %h want %h", c, g, e); end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    g = observe(); e = '0; e.rd_addr = 8'hFF;
    checks++;
    if (g !== e) begin errors++; $display("FAIL loop_stop: got %h want %h", g, e); end
  endtask

  task automatic test_zero_len_and_busy_start();
    obs_t g, e;
    logic [3:0] want;
    int rd_seen;
    rd_seen = 0;
    launch(8'h77, 8'd0, 1'b0, 2'd0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      want = (c == 1) ? 4'b1100 : 4'b0000;
      checks++;
      if ({busy, done, rd_en, pwm} !== want) begin
        errors++; $display("FAIL zero_len c=%0d: got %b want %b", c, {busy, done, rd_en, pwm}, want);
      end
      if (rd_en === 1'b1) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin errors++; $display("FAIL zero_len_rd_en: got %0d strobes want 0", rd_seen); end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, rd_en} !== 2'b00) begin
      errors++; $display("FAIL start_with_stop: got busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
    mem[8'h40] = 16'($urandom); mem[8'h41] = 16'($urandom);
    launch(8'h40, 8'd2, 1'b0, 2'd2);
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) @(negedge clk);
      g = observe(); e = model(c, 'h40, 2, 1'b0, 2);
      checks++;
      if (g !== e) begin errors++; $display("FAIL busy_start c=%0d: got %h want %h", c, g, e); end
      if (c == 5) begin start = 1'b1; start_addr = 8'h55; length = 8'd7; loop = 1'b1; end
      if (c == 6) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_play();
    obs_t g, e;
    logic [1:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    launch(8'h30, 8'd3, 1'b0, 2'd0);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      g = observe(); e = model(c, 'h30, 3, 1'b0, 0);
      checks++;
      if (g !== e) begin errors++; $display("FAIL pre_reset c=%0d: got %h want %h", c, g, e); end
    end
    rst = 1'b1;
    @(negedge clk);
    g = observe();
    checks++;
    if (g !== obs_t'('0)) begin errors++; $display("FAIL mid_reset: got %h want %h", g, obs_t'('0)); end
    a = 2'($urandom_range(0, 3));
    rst = 1'b0; start = 1'b1; start_addr = 8'h60; length = 8'd2; loop = 1'b0; att = a;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) @(negedge clk);
      g = observe(); e = model(c, 'h60, 2, 1'b0, int'(a));
      checks++;
      if (g !== e) begin errors++; $display("FAIL post_reset c=%0d: got %h want %h", c, g, e); end
    end
  endtask

  task automatic test_random();
    obs_t g, e;
    int sa, len, a, ncyc;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      sa  = int'($urandom_range(0, 255));
      len = int'($urandom_range(1, 4));
      a   = int'($urandom_range(0, 3));
      launch(8'(sa), 8'(len), 1'b0, 2'(a));
      for (int c = 1; c <= len * CPS + 3; c++) begin
        if (c > 1) @(negedge clk);
        g = observe(); e = model(c, sa, len, 1'b0, a);
        checks++;
        if (g !== e) begin errors++; $display("FAIL random%0d c=%0d: got %h want %h", it, c, g, e); end
      end
    end
    sa = int'($urandom_range(0, 255)); len = int'($urandom_range(1, 3));
    a = int'($urandom_range(0, 3)); ncyc = int'($urandom_range(40, 80));
    launch(8'(sa), 8'(len), 1'b1, 2'(a));
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      g = observe(); e = model(c, sa, len, 1'b1, a);
      checks++;
      if (g !== e) begin errors++; $display("FAIL random_loop c=%0d: got %h want %h", c, g, e); end
    end
    e = model(ncyc, sa, len, 1'b1, a);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    g = observe();
    e = '{1'b0, 1'b0, 1'b0, 1'b0, e.rd_addr, 16'h0};
    checks++;
    if (g !== e) begin errors++; $display("FAIL random_stop: got %h want %h", g, e); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_atten();
    test_loop_stop();
    test_zero_len_and_busy_start();
    test_reset_mid_play();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
